// File: rtl/ssd_pkg.sv
// Shared constants and the hex-to-segment table for the seven-segment scan controller.
package ssd_pkg;

    localparam int unsigned SEG_W       = 7;
    localparam int unsigned CATH_W      = 8;
    // Cathode vector order is {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}; Dp sits in the LSB.
    localparam int unsigned CATH_DP_BIT = 0;
    localparam int unsigned SLOTS       = 16;
    localparam int unsigned SLOT_W      = 4;

    // Active-low abcdefg pattern for one hex nibble.
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
        logic [SEG_W-1:0] seg;
        seg = 7'b1111111;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational nibble + decimal-point to active-low cathode pattern.
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0]        nibble,
    input  logic              dp,
    output logic [CATH_W-1:0] cathodes_c
);

    // Segments in the upper bits, inverted decimal point in the LSB.
    always_comb begin
        cathodes_c              = {hex_to_seg(nibble), 1'b1};
        cathodes_c[CATH_DP_BIT] = ~dp;
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with blanking, blink, PWM brightness
// and a frame-synchronous double-buffered load.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 8,
    parameter int unsigned DWELL_CYCLES = 12500,
    parameter int unsigned BLINK_FRAMES = 256
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [4*N_DIGITS-1:0]   digit_data,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic [N_DIGITS-1:0]     blink_mask,
    input  logic [3:0]              brightness,
    input  logic                    load,
    output logic                    load_ack,
    output logic                    frame_start,
    output logic [N_DIGITS-1:0]     anodes,
    output logic [CATH_W-1:0]       cathodes
);

    localparam int unsigned IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned DWELL_W  = $clog2(DWELL_CYCLES);
    localparam int unsigned SLOT_LEN = DWELL_CYCLES / SLOTS;
    localparam int unsigned SDIV_W   = $clog2(SLOT_LEN);
    localparam int unsigned FRM_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DWELL_W-1:0]    dwell_cnt;
    logic [SDIV_W-1:0]     slot_div;
    logic [SLOT_W-1:0]     slot;
    logic [IDX_W-1:0]      idx;
    logic [FRM_W-1:0]      frame_cnt;
    logic                  blink_phase;

    logic [4*N_DIGITS-1:0] sh_data, act_data;
    logic [N_DIGITS-1:0]   sh_dp, act_dp;
    logic [N_DIGITS-1:0]   sh_en, act_en;
    logic [N_DIGITS-1:0]   sh_blink, act_blink;
    logic                  pending;

    logic                  dwell_last_c, slot_last_c, idx_last_c, frame_last_c, commit_c;
    logic [3:0]            cur_nib_c;
    logic                  cur_dp_c, cur_en_c, cur_blink_c, anode_on_c;
    logic [N_DIGITS-1:0]   anodes_nxt_c;
    logic [CATH_W-1:0]     cath_nxt_c;

    // Terminal-count decodes; the commit cycle is the last cycle of the last dwell.
    always_comb begin
        dwell_last_c = (dwell_cnt == DWELL_W'(DWELL_CYCLES - 1));
        slot_last_c  = (slot_div == SDIV_W'(SLOT_LEN - 1));
        idx_last_c   = (idx == IDX_W'(N_DIGITS - 1));
        frame_last_c = (frame_cnt == FRM_W'(BLINK_FRAMES - 1));
        commit_c     = dwell_last_c && idx_last_c;
    end

    // Dwell, PWM slot, digit index and blink frame counters.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dwell_cnt   <= '0;
            slot_div    <= '0;
            slot        <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (dwell_last_c) begin
                dwell_cnt <= '0;
                slot_div  <= '0;
                slot      <= '0;
                idx       <= idx_last_c ? '0 : idx + IDX_W'(1);
            end else begin
                dwell_cnt <= dwell_cnt + DWELL_W'(1);
                if (slot_last_c) begin
                    slot_div <= '0;
                    slot     <= slot + SLOT_W'(1);
                end else begin
                    slot_div <= slot_div + SDIV_W'(1);
                end
            end
            if (commit_c) begin
                frame_cnt <= frame_last_c ? '0 : frame_cnt + FRM_W'(1);
                if (frame_last_c) begin
                    blink_phase <= ~blink_phase;
                end
            end
        end
    end

    // Shadow capture on load; shadow moves to active only at the commit cycle,
    // so a load landing in the commit cycle itself waits for the next frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sh_data   <= '0;
            sh_dp     <= '0;
            sh_en     <= '0;
            sh_blink  <= '0;
            act_data  <= '0;
            act_dp    <= '0;
            act_en    <= '0;
            act_blink <= '0;
            pending   <= 1'b0;
        end else begin
            if (commit_c && pending) begin
                act_data  <= sh_data;
                act_dp    <= sh_dp;
                act_en    <= sh_en;
                act_blink <= sh_blink;
            end
            if (load) begin
                sh_data  <= digit_data;
                sh_dp    <= dp_in;
                sh_en    <= digit_en;
                sh_blink <= blink_mask;
                pending  <= 1'b1;
            end else if (commit_c) begin
                pending  <= 1'b0;
            end
        end
    end

    // Select the active per-digit fields for the current index.
    always_comb begin
        cur_nib_c   = '0;
        cur_dp_c    = 1'b0;
        cur_en_c    = 1'b0;
        cur_blink_c = 1'b0;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (IDX_W'(i) == idx) begin
                cur_nib_c   = act_data[4*i +: 4];
                cur_dp_c    = act_dp[i];
                cur_en_c    = act_en[i];
                cur_blink_c = act_blink[i];
            end
        end
    end

    // Anode gating: enable, anti-ghost dead cycle, PWM slot and blink.
    always_comb begin
        anode_on_c   = cur_en_c && (dwell_cnt != '0) && (slot <= brightness) &&
                       !(blink_phase && cur_blink_c);
        anodes_nxt_c = '1;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (anode_on_c && (IDX_W'(i) == idx)) begin
                anodes_nxt_c[i] = 1'b0;
            end
        end
    end

    ssd_hex_decoder u_dec (
        .nibble     (cur_nib_c),
        .dp         (cur_dp_c),
        .cathodes_c (cath_nxt_c)
    );

    // Registered pin drive and frame/commit pulses.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            anodes      <= '1;
            cathodes    <= '1;
            frame_start <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            anodes      <= anodes_nxt_c;
            cathodes    <= cath_nxt_c;
            frame_start <= commit_c;
            load_ack    <= commit_c && pending;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl with a cycle-level behavioural model.
module tb_ssd_scan_ctrl;

    localparam int N     = 4;
    localparam int D     = 32;
    localparam int B     = 2;
    localparam int FRAME = N * D;

    logic         Clk = 1'b0;
    logic         Reset_n;
    logic [15:0]  digit_data;
    logic [3:0]   dp_in, digit_en, blink_mask, brightness;
    logic         load;
    logic         load_ack, frame_start;
    logic [3:0]   anodes;
    logic [7:0]   cathodes;

    always #5 Clk = ~Clk;

    ssd_scan_ctrl #(.N_DIGITS(N), .DWELL_CYCLES(D), .BLINK_FRAMES(B)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .digit_data  (digit_data),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .blink_mask  (blink_mask),
        .brightness  (brightness),
        .load        (load),
        .load_ack    (load_ack),
        .frame_start (frame_start),
        .anodes      (anodes),
        .cathodes    (cathodes)
    );

    logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    int tests = 0;
    int fails = 0;
    int t;
    logic [15:0] m_data, s_data;
    logic [3:0]  m_dp, m_en, m_blink, s_dp, s_en, s_blink;
    logic        m_pend;
    int          low_cnt [N];
    int          ack_cnt, fs_cnt;
    logic [7:0]  cath_d0, cath_d1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s t=%0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        m_data = '0; m_dp = '0; m_en = '0; m_blink = '0;
        s_data = '0; s_dp = '0; s_en = '0; s_blink = '0;
        m_pend = 1'b0;
    endtask

    task automatic clear_obs();
        for (int i = 0; i < N; i++) low_cnt[i] = 0;
        ack_cnt = 0;
        fs_cnt  = 0;
        cath_d0 = 'x;
        cath_d1 = 'x;
    endtask

    // One clock: predict outputs from frame position t, advance, compare.
    task automatic tick();
        int pos, d, dw, sl, fr;
        logic bp, on, e_fs, e_ack;
        logic [3:0] e_an;
        logic [7:0] e_ca;
        pos = t % FRAME;
        d   = pos / D;
        dw  = pos % D;
        sl  = dw / (D / 16);
        fr  = t / FRAME;
        bp  = ((fr / B) % 2) == 1;
        on  = m_en[d] && (dw != 0) && (sl <= int'(brightness)) && !(bp && m_blink[d]);
        e_an = 4'hF;
        if (on) e_an[d] = 1'b0;
        e_ca  = {seg_tab[m_data[d*4 +: 4]], ~m_dp[d]};
        e_fs  = (pos == FRAME - 1);
        e_ack = e_fs && m_pend;
        if (e_ack) begin
            m_data = s_data; m_dp = s_dp; m_en = s_en; m_blink = s_blink;
            m_pend = 1'b0;
        end
        if (load) begin
            s_data = digit_data; s_dp = dp_in; s_en = digit_en; s_blink = blink_mask;
            m_pend = 1'b1;
        end
        t++;
        @(posedge Clk);
        #1;
        chk("anodes", 32'(anodes), 32'(e_an));
        chk("cathodes", 32'(cathodes), 32'(e_ca));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("load_ack", 32'(load_ack), 32'(e_ack));
        for (int i = 0; i < N; i++) if (!anodes[i]) low_cnt[i]++;
        ack_cnt += int'(load_ack);
        fs_cnt  += int'(frame_start);
        if (anodes == 4'b1110) cath_d0 = cathodes;
        if (anodes == 4'b1101) cath_d1 = cathodes;
        load = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] dd, input logic [3:0] dp,
                           input logic [3:0] en, input logic [3:0] bl);
        digit_data = dd; dp_in = dp; digit_en = en; blink_mask = bl;
        load = 1'b1;
        tick();
    endtask

    task automatic align();
        while (t % FRAME != 0) tick();
    endtask

    task automatic run_frames(input int n);
        for (int k = 0; k < n * FRAME; k++) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0;
        digit_data = '0; dp_in = '0; digit_en = '0; blink_mask = '0;
        brightness = 4'd15; load = 1'b0;
        model_reset();
        clear_obs();
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_anodes", 32'(anodes), 32'h0F);
        chk("rst_cathodes", 32'(cathodes), 32'hFF);
        chk("rst_frame_start", 32'(frame_start), 32'h0);
        chk("rst_load_ack", 32'(load_ack), 32'h0);
        Reset_n = 1'b1;

        // Mid-frame asynchronous reset with a load pending.
        repeat (50) tick();
        do_load(16'($urandom), 4'($urandom), 4'hF, 4'h0);
        repeat (20) tick();
        #2 Reset_n = 1'b0;
        #1;
        chk("async_rst_anodes", 32'(anodes), 32'h0F);
        chk("async_rst_cathodes", 32'(cathodes), 32'hFF);
        chk("async_rst_frame_start", 32'(frame_start), 32'h0);
        chk("async_rst_load_ack", 32'(load_ack), 32'h0);
        @(posedge Clk);
        #1;
        chk("held_rst_anodes", 32'(anodes), 32'h0F);
        model_reset();
        clear_obs();
        Reset_n = 1'b1;
        repeat (FRAME - 1) tick();
        chk("no_fs_before_128", 32'(fs_cnt), 32'd0);
        tick();
        chk("first_fs_at_128", 32'(frame_start), 32'd1);
        chk("no_ack_after_reset", 32'(ack_cnt), 32'd0);

        // Basic load and display at full brightness.
        repeat ($urandom_range(1, 60)) tick();
        clear_obs();
        brightness = 4'd15;
        do_load(16'hA50F, 4'b0010, 4'hF, 4'h0);
        align();
        chk("ack_count_first_load", 32'(ack_cnt), 32'd1);
        chk("fs_count_first_load", 32'(fs_cnt), 32'd1);
        clear_obs();
        run_frames(1);
        for (int i = 0; i < N; i++) chk("low_cycles_b15", 32'(low_cnt[i]), 32'd31);
        chk("digit0_cathodes", 32'(cath_d0), 32'b01110001);
        chk("digit1_cathodes", 32'(cath_d1), 32'b00000010);

        // Brightness takes effect immediately.
        brightness = 4'd0;
        clear_obs();
        run_frames(1);
        for (int i = 0; i < N; i++) chk("low_cycles_b0", 32'(low_cnt[i]), 32'd1);
        brightness = 4'd7;
        clear_obs();
        run_frames(1);
        for (int i = 0; i < N; i++) chk("low_cycles_b7", 32'(low_cnt[i]), 32'd15);
        brightness = 4'd15;

        // Blink on digit 1 only.
        do_load(16'hA50F, 4'b0010, 4'hF, 4'b0010);
        align();
        for (int k = 0; k < 4; k++) begin
            int f;
            f = t / FRAME;
            clear_obs();
            run_frames(1);
            chk("blink_digit1", 32'(low_cnt[1]), ((f / B) % 2) == 1 ? 32'd0 : 32'd31);
            chk("blink_digit0", 32'(low_cnt[0]), 32'd31);
            chk("blink_digit3", 32'(low_cnt[3]), 32'd31);
        end

        // Load landing in the commit cycle waits one more frame.
        repeat (40) tick();
        clear_obs();
        do_load(16'h1234, 4'h0, 4'hF, 4'h0);
        while (t % FRAME != FRAME - 1) tick();
        do_load(16'h5678, 4'hF, 4'hF, 4'h0);
        chk("commit_cycle_ack1", 32'(ack_cnt), 32'd1);
        run_frames(1);
        chk("commit_cycle_old_data", 32'(cath_d0), 32'b10011001);
        chk("commit_cycle_ack2", 32'(ack_cnt), 32'd2);
        run_frames(1);
        chk("commit_cycle_new_data", 32'(cath_d0), 32'b00000000);
        chk("commit_cycle_ack_total", 32'(ack_cnt), 32'd2);

        // All digits disabled: anodes dark, frame_start keeps pulsing.
        do_load(16'($urandom), 4'($urandom), 4'h0, 4'($urandom));
        align();
        clear_obs();
        run_frames(2);
        for (int i = 0; i < N; i++) chk("disabled_low", 32'(low_cnt[i]), 32'd0);
        chk("disabled_fs_count", 32'(fs_cnt), 32'd2);

        // Randomised loads (including back-to-back) and brightness.
        for (int it = 0; it < 8; it++) begin
            int nl;
            nl = (it == 0) ? 2 : $urandom_range(0, 2);
            brightness = 4'($urandom);
            clear_obs();
            tick();
            for (int l = 0; l < nl; l++) begin
                repeat ($urandom_range(0, 50)) tick();
                do_load(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            end
            align();
            chk("random_ack_count", 32'(ack_cnt), (nl > 0) ? 32'd1 : 32'd0);
            run_frames(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
